// File: rtl/pipe_mac_pkg.sv
// pipe_mac shared types and helpers.
// sat_shift is shared with the other audio datapath blocks.
package pipe_mac_pkg;

  localparam int SAT_W = 128;

  typedef struct packed {
    logic                    clip;
    logic signed [SAT_W-1:0] val;
  } sat_t;

  function automatic int prod_w(input int a_w, input int b_w);
    return a_w + b_w + 1;
  endfunction

  // Arithmetic (floor) shift, then clip to the signed out_w range.
  function automatic sat_t sat_shift(
    input logic signed [SAT_W-1:0] value,
    input int                      shift,
    input int                      out_w
  );
    logic signed [SAT_W-1:0] s;
    logic signed [SAT_W-1:0] hi;
    logic signed [SAT_W-1:0] lo;
    sat_t r;
    s  = value >>> shift;
    hi = (SAT_W'(1) << (out_w - 1)) - SAT_W'(1);
    lo = ~hi;
    r.clip = 1'b0;
    r.val  = s;
    if (s > hi) begin
      r.clip = 1'b1;
      r.val  = hi;
    end else if (s < lo) begin
      r.clip = 1'b1;
      r.val  = lo;
    end
    return r;
  endfunction

endpackage

// File: rtl/pipe_mac_if.sv
// pipe_mac sample stream in, frame result out.
// master = sample source / result sink, slave = the MAC.
interface pipe_mac_if #(
  parameter int A_W   = 17,
  parameter int B_W   = 17,
  parameter int ACC_W = 48,
  parameter int OUT_W = 24
);
  logic             ce;
  logic             in_valid;
  logic [A_W-1:0]   a;
  logic [B_W-1:0]   b;
  logic             a_signed;
  logic             b_signed;
  logic             acc_en;
  logic             last;
  logic             out_valid;
  logic [ACC_W-1:0] acc;
  logic [OUT_W-1:0] sat_out;
  logic             overflow;
  logic             sat_flag;

  modport master (
    output ce, in_valid, a, b, a_signed, b_signed, acc_en, last,
    input  out_valid, acc, sat_out, overflow, sat_flag
  );

  modport slave (
    input  ce, in_valid, a, b, a_signed, b_signed, acc_en, last,
    output out_valid, acc, sat_out, overflow, sat_flag
  );
endinterface

// File: rtl/pipe_mac_mul.sv
// Signedness-extended multiplier plus product/sideband delay line.
// Kept separate so a DSP primitive wrapper can replace it.
module pipe_mac_mul
  import pipe_mac_pkg::*;
#(
  parameter int A_W         = 17,
  parameter int B_W         = 17,
  parameter int PIPE_STAGES = 3,
  localparam int PROD_W     = prod_w(A_W, B_W)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     ce,
  input  logic                     in_valid,
  input  logic [A_W-1:0]           a,
  input  logic [B_W-1:0]           b,
  input  logic                     a_signed,
  input  logic                     b_signed,
  input  logic                     acc_en,
  input  logic                     last,
  output logic signed [PROD_W-1:0] prod,
  output logic                     p_valid,
  output logic                     p_acc_en,
  output logic                     p_last
);

  logic signed [A_W:0]    ax_q;
  logic signed [B_W:0]    bx_q;
  logic                   v_q;
  logic                   en_q;
  logic                   l_q;
  logic signed [PROD_W-1:0] prod_c;

  logic signed [PROD_W-1:0] p_q [PIPE_STAGES];
  logic [PIPE_STAGES-1:0]   vs;
  logic [PIPE_STAGES-1:0]   es;
  logic [PIPE_STAGES-1:0]   ls;

  // Exact: the extended operands' product always fits PROD_W bits.
  assign prod_c = PROD_W'(ax_q) * PROD_W'(bx_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ax_q <= '0;
      bx_q <= '0;
      v_q  <= 1'b0;
      en_q <= 1'b0;
      l_q  <= 1'b0;
      vs   <= '0;
      es   <= '0;
      ls   <= '0;
      for (int i = 0; i < PIPE_STAGES; i++)
        p_q[i] <= '0;
    end else if (ce) begin
      ax_q   <= {a_signed & a[A_W-1], a};
      bx_q   <= {b_signed & b[B_W-1], b};
      v_q    <= in_valid;
      en_q   <= acc_en;
      l_q    <= last;
      p_q[0] <= prod_c;
      vs[0]  <= v_q;
      es[0]  <= en_q;
      ls[0]  <= l_q;
      for (int i = 1; i < PIPE_STAGES; i++) begin
        p_q[i] <= p_q[i-1];
        vs[i]  <= vs[i-1];
        es[i]  <= es[i-1];
        ls[i]  <= ls[i-1];
      end
    end
  end

  assign prod     = p_q[PIPE_STAGES-1];
  assign p_valid  = vs[PIPE_STAGES-1];
  assign p_acc_en = es[PIPE_STAGES-1];
  assign p_last   = ls[PIPE_STAGES-1];

endmodule

// File: rtl/pipe_mac.sv
// Pipelined multiply-accumulate with frame results,
// wrap detection and a shifted, saturated narrow output.
module pipe_mac
  import pipe_mac_pkg::*;
#(
  parameter int A_W         = 17,
  parameter int B_W         = 17,
  parameter int ACC_W       = 48,
  parameter int PIPE_STAGES = 3,
  parameter int OUT_W       = 24,
  parameter int SHIFT       = 15
) (
  input  logic      clk,
  input  logic      rst,
  pipe_mac_if.slave io
);

  localparam int PROD_W = prod_w(A_W, B_W);

  if (ACC_W < PROD_W) begin : g_bad_acc
    $error("pipe_mac: ACC_W must be >= A_W+B_W+1");
  end
  if (PIPE_STAGES < 1 || PIPE_STAGES > 5) begin : g_bad_pipe
    $error("pipe_mac: PIPE_STAGES must be 1..5");
  end
  if (SHIFT > ACC_W - OUT_W) begin : g_bad_shift
    $error("pipe_mac: SHIFT must be <= ACC_W-OUT_W");
  end

  logic signed [PROD_W-1:0] m_prod;
  logic                     m_valid;
  logic                     m_acc_en;
  logic                     m_last;

  pipe_mac_mul #(
    .A_W        (A_W),
    .B_W        (B_W),
    .PIPE_STAGES(PIPE_STAGES)
  ) u_mul (
    .clk     (clk),
    .rst     (rst),
    .ce      (io.ce),
    .in_valid(io.in_valid),
    .a       (io.a),
    .b       (io.b),
    .a_signed(io.a_signed),
    .b_signed(io.b_signed),
    .acc_en  (io.acc_en),
    .last    (io.last),
    .prod    (m_prod),
    .p_valid (m_valid),
    .p_acc_en(m_acc_en),
    .p_last  (m_last)
  );

  logic signed [ACC_W-1:0] acc_q;
  logic signed [ACC_W-1:0] prod_x;
  logic signed [ACC_W-1:0] sum;
  logic signed [ACC_W-1:0] acc_d;
  logic [OUT_W-1:0]        sat_q;
  logic [OUT_W-1:0]        sat_d;
  sat_t                    sat_r;
  logic                    add_ovf;
  logic                    load;
  logic                    ovf_q;
  logic                    flag_q;
  logic                    ov_q;
  logic                    started_q;

  // started_q forces the first sample after reset to load.
  always_comb begin
    prod_x  = ACC_W'(m_prod);
    sum     = acc_q + prod_x;
    add_ovf = (acc_q[ACC_W-1] == prod_x[ACC_W-1]) &&
              (sum[ACC_W-1] != acc_q[ACC_W-1]);
    load    = !m_acc_en || !started_q;
    acc_d   = load ? prod_x : sum;
    sat_r   = sat_shift(SAT_W'(acc_d), SHIFT, OUT_W);
    sat_d   = OUT_W'(sat_r.val);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q     <= '0;
      sat_q     <= '0;
      ovf_q     <= 1'b0;
      flag_q    <= 1'b0;
      ov_q      <= 1'b0;
      started_q <= 1'b0;
    end else if (io.ce) begin
      ov_q <= m_valid & m_last;
      if (m_valid) begin
        acc_q     <= acc_d;
        sat_q     <= sat_d;
        flag_q    <= sat_r.clip;
        ovf_q     <= !load & (ovf_q | add_ovf);
        started_q <= 1'b1;
      end
    end
  end

  assign io.out_valid = ov_q;
  assign io.acc       = acc_q;
  assign io.sat_out   = sat_q;
  assign io.overflow  = ovf_q;
  assign io.sat_flag  = flag_q;

endmodule

// File: tb/tb_pipe_mac.sv
// pipe_mac bench: default build and a 36-bit / 1-stage / SHIFT=0 build
// share one stimulus stream; directed tables, corner sequences, random.
module tb_pipe_mac;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        ce;
  logic        vld;
  logic [16:0] a;
  logic [16:0] b;
  logic        as_;
  logic        bs_;
  logic        en;
  logic        lst;

  pipe_mac_if #(.A_W(17), .B_W(17), .ACC_W(48), .OUT_W(24)) i0 ();
  pipe_mac_if #(.A_W(17), .B_W(17), .ACC_W(36), .OUT_W(24)) i1 ();

  assign i0.ce = ce;        assign i1.ce = ce;
  assign i0.in_valid = vld; assign i1.in_valid = vld;
  assign i0.a = a;          assign i1.a = a;
  assign i0.b = b;          assign i1.b = b;
  assign i0.a_signed = as_; assign i1.a_signed = as_;
  assign i0.b_signed = bs_; assign i1.b_signed = bs_;
  assign i0.acc_en = en;    assign i1.acc_en = en;
  assign i0.last = lst;     assign i1.last = lst;

  pipe_mac #(
    .A_W(17), .B_W(17), .ACC_W(48),
    .PIPE_STAGES(3), .OUT_W(24), .SHIFT(15)
  ) u0 (.clk(clk), .rst(rst), .io(i0));

  pipe_mac #(
    .A_W(17), .B_W(17), .ACC_W(36),
    .PIPE_STAGES(1), .OUT_W(24), .SHIFT(0)
  ) u1 (.clk(clk), .rst(rst), .io(i1));

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int t_mark = 0;
  int pulses0 = 0;
  bit rnd_on = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (ce && i0.out_valid) pulses0 <= pulses0 + 1;

  typedef struct {
    longint acc;
    longint sat;
    bit     flag;
    bit     ovf;
  } exp_t;

  typedef struct {
    logic [16:0] a;
    logic [16:0] b;
    logic        as_;
    logic        bs_;
    longint      acc;
    longint      sat;
    bit          flag;
  } vec_t;

  exp_t   q0[$];
  exp_t   q1[$];
  longint m_sum[2];
  bit     m_ovf[2];
  bit     m_started;

  task automatic chk(input string nm, input logic signed [63:0] act,
                     input logic signed [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic logic signed [63:0] o_acc(input int s);
    return s != 0 ? {{28{i1.acc[35]}}, i1.acc}
                  : {{16{i0.acc[47]}}, i0.acc};
  endfunction

  function automatic logic signed [63:0] o_sat(input int s);
    return s != 0 ? {{40{i1.sat_out[23]}}, i1.sat_out}
                  : {{40{i0.sat_out[23]}}, i0.sat_out};
  endfunction

  function automatic logic o_ov(input int s);
    return s != 0 ? i1.out_valid : i0.out_valid;
  endfunction

  function automatic logic o_ovf(input int s);
    return s != 0 ? i1.overflow : i0.overflow;
  endfunction

  function automatic logic o_flag(input int s);
    return s != 0 ? i1.sat_flag : i0.sat_flag;
  endfunction

  // Reference arithmetic on plain integers.
  function automatic longint prod(input logic [16:0] x, input logic [16:0] y,
                                  input logic xs, input logic ys);
    longint xv;
    longint yv;
    xv = longint'(x);
    yv = longint'(y);
    if (xs && x[16]) xv -= 131072;
    if (ys && y[16]) yv -= 131072;
    return xv * yv;
  endfunction

  function automatic longint wrap(input longint v, input int w);
    longint m;
    longint r;
    m = 64'sd1 <<< w;
    r = v % m;
    if (r >= m / 2) r -= m;
    else if (r < -(m / 2)) r += m;
    return r;
  endfunction

  function automatic exp_t ref_res(input longint acc, input bit ovf,
                                   input int sh);
    exp_t   e;
    longint s;
    s = acc >>> sh;
    e.acc = acc;
    e.ovf = ovf;
    e.flag = 1'b0;
    e.sat = s;
    if (s > 8388607) begin
      e.sat = 8388607;
      e.flag = 1'b1;
    end else if (s < -8388608) begin
      e.sat = -8388608;
      e.flag = 1'b1;
    end
    return e;
  endfunction

  task automatic model_take(input logic [16:0] x, input logic [16:0] y,
                            input logic xs, input logic ys,
                            input logic e, input logic l);
    longint p;
    longint t;
    longint lim;
    int     w;
    p = prod(x, y, xs, ys);
    for (int s = 0; s < 2; s++) begin
      w = s != 0 ? 36 : 48;
      lim = 64'sd1 <<< (w - 1);
      if (!e || !m_started) begin
        m_sum[s] = wrap(p, w);
        m_ovf[s] = 1'b0;
      end else begin
        t = m_sum[s] + p;
        if (t >= lim || t < -lim) m_ovf[s] = 1'b1;
        m_sum[s] = wrap(t, w);
      end
      if (l) begin
        if (s == 0) q0.push_back(ref_res(m_sum[0], m_ovf[0], 15));
        else        q1.push_back(ref_res(m_sum[1], m_ovf[1], 0));
      end
    end
    m_started = 1'b1;
  endtask

  task automatic check_pop(input int s);
    exp_t e;
    int   n;
    n = s != 0 ? q1.size() : q0.size();
    if (n == 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL rnd_spurious%0d: got out_valid expected none", s);
      return;
    end
    if (s != 0) e = q1.pop_front();
    else        e = q0.pop_front();
    chk($sformatf("rnd_acc%0d", s), o_acc(s), e.acc);
    chk($sformatf("rnd_sat%0d", s), o_sat(s), e.sat);
    chk($sformatf("rnd_flag%0d", s), o_flag(s), 64'(e.flag));
    chk($sformatf("rnd_ovf%0d", s), o_ovf(s), 64'(e.ovf));
  endtask

  always @(negedge clk) begin
    if (rnd_on && ce) begin
      if (i0.out_valid) check_pop(0);
      if (i1.out_valid) check_pop(1);
    end
  end

  task automatic drv(input logic [16:0] ta, input logic [16:0] tb,
                     input logic tas, input logic tbs,
                     input logic ten, input logic tl);
    a = ta; b = tb; as_ = tas; bs_ = tbs;
    en = ten; lst = tl; vld = 1'b1;
    @(posedge clk);
    #1;
    vld = 1'b0; en = 1'b0; lst = 1'b0;
    t_mark = cyc;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Latency in cycles from the cycle the last sample was presented.
  task automatic wait_ov(input int s, output int lat);
    lat = -1;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (ce && o_ov(s)) begin
        lat = cyc - t_mark + 1;
        break;
      end
    end
  endtask

  task automatic chk_zero(input string nm);
    for (int s = 0; s < 2; s++) begin
      chk($sformatf("%s_acc%0d", nm, s), o_acc(s), 0);
      chk($sformatf("%s_sat%0d", nm, s), o_sat(s), 0);
      chk($sformatf("%s_ov%0d", nm, s), o_ov(s), 0);
      chk($sformatf("%s_ovf%0d", nm, s), o_ovf(s), 0);
      chk($sformatf("%s_flag%0d", nm, s), o_flag(s), 0);
    end
  endtask

  vec_t tv[6];

  initial begin
    int   lat;
    int   p0;
    exp_t r1;

    tv[0] = '{17'd3, 17'h1FFFE, 1'b1, 1'b1, -64'sd6, -64'sd1, 1'b0};
    tv[1] = '{17'h1FFFF, 17'h1FFFF, 1'b0, 1'b1,
              -64'sd131071, -64'sd4, 1'b0};
    tv[2] = '{17'h1FFFF, 17'h1FFFF, 1'b0, 1'b0,
              64'sd17179607041, 64'sd524280, 1'b0};
    tv[3] = '{17'h10000, 17'h10000, 1'b1, 1'b1,
              64'sd4294967296, 64'sd131072, 1'b0};
    tv[4] = '{17'h10000, 17'h0FFFF, 1'b1, 1'b0,
              -64'sd4294901760, -64'sd131070, 1'b0};
    tv[5] = '{17'd0, 17'h1ABCD, 1'b1, 1'b1, 64'sd0, 64'sd0, 1'b0};

    ce = 1'b1; vld = 1'b0; a = '0; b = '0;
    as_ = 1'b0; bs_ = 1'b0; en = 1'b0; lst = 1'b0;
    rst = 1'b1;
    idle(3);
    chk_zero("reset");
    rst = 1'b0;
    idle(1);

    // Single-sample frames, both builds.
    for (int i = 0; i < 6; i++) begin
      drv(tv[i].a, tv[i].b, tv[i].as_, tv[i].bs_, 1'b0, 1'b1);
      r1 = ref_res(wrap(prod(tv[i].a, tv[i].b, tv[i].as_, tv[i].bs_), 36),
                   1'b0, 0);
      wait_ov(1, lat);
      chk($sformatf("v%0d_lat1", i), lat, 3);
      chk($sformatf("v%0d_acc1", i), o_acc(1), r1.acc);
      chk($sformatf("v%0d_sat1", i), o_sat(1), r1.sat);
      chk($sformatf("v%0d_flag1", i), o_flag(1), 64'(r1.flag));
      wait_ov(0, lat);
      chk($sformatf("v%0d_lat0", i), lat, 5);
      chk($sformatf("v%0d_acc0", i), o_acc(0), tv[i].acc);
      chk($sformatf("v%0d_sat0", i), o_sat(0), tv[i].sat);
      chk($sformatf("v%0d_flag0", i), o_flag(0), 64'(tv[i].flag));
      chk($sformatf("v%0d_ovf0", i), o_ovf(0), 0);
      idle(2);
    end

    // Four-sample frame: one pulse only.
    p0 = pulses0;
    drv(17'd1000, 17'd1000, 1'b1, 1'b1, 1'b0, 1'b0);
    drv(17'd1000, 17'd1000, 1'b1, 1'b1, 1'b1, 1'b0);
    drv(17'd1000, 17'd1000, 1'b1, 1'b1, 1'b1, 1'b0);
    drv(17'd1000, 17'd1000, 1'b1, 1'b1, 1'b1, 1'b1);
    wait_ov(0, lat);
    chk("frame4_lat", lat, 5);
    chk("frame4_acc", o_acc(0), 4000000);
    chk("frame4_sat", o_sat(0), 122);
    chk("frame4_ovf", o_ovf(0), 0);
    idle(4);
    chk("frame4_pulses", pulses0 - p0, 1);

    // 16 x 2^32 wraps the 36-bit accumulator to 0.
    for (int k = 0; k < 16; k++)
      drv(17'h10000, 17'h10000, 1'b0, 1'b0, k != 0, k == 15);
    wait_ov(1, lat);
    chk("wrap_acc1", o_acc(1), 0);
    chk("wrap_ovf1", o_ovf(1), 1);
    chk("wrap_flag1", o_flag(1), 0);
    chk("wrap_sat1", o_sat(1), 0);
    wait_ov(0, lat);
    chk("wrap_acc0", o_acc(0), 64'sd68719476736);
    chk("wrap_ovf0", o_ovf(0), 0);
    chk("wrap_sat0", o_sat(0), 2097152);
    idle(2);
    drv(17'd1, 17'd1, 1'b0, 1'b0, 1'b0, 1'b1);
    wait_ov(1, lat);
    chk("reload_ovf1", o_ovf(1), 0);
    chk("reload_acc1", o_acc(1), 1);
    idle(4);

    // Saturation on the SHIFT=0 build.
    drv(17'h08000, 17'h08000, 1'b1, 1'b1, 1'b0, 1'b1);
    wait_ov(1, lat);
    chk("satp_acc1", o_acc(1), 64'sd1073741824);
    chk("satp_sat1", o_sat(1), 8388607);
    chk("satp_flag1", o_flag(1), 1);
    wait_ov(0, lat);
    chk("satp_sat0", o_sat(0), 32768);
    chk("satp_flag0", o_flag(0), 0);
    idle(2);
    drv(17'h18000, 17'h08000, 1'b1, 1'b1, 1'b0, 1'b1);
    wait_ov(1, lat);
    chk("satn_sat1", o_sat(1), -8388608);
    chk("satn_flag1", o_flag(1), 1);
    wait_ov(0, lat);
    chk("satn_sat0", o_sat(0), -32768);
    idle(2);

    // ce low for 3 cycles delays the result by exactly 3.
    drv(17'd7, 17'd9, 1'b0, 1'b0, 1'b0, 1'b0);
    drv(17'd5, 17'd5, 1'b0, 1'b0, 1'b1, 1'b1);
    ce = 1'b0;
    idle(3);
    ce = 1'b1;
    wait_ov(0, lat);
    chk("stall_lat", lat, 8);
    chk("stall_acc", o_acc(0), 88);
    idle(2);

    // A pulse held by ce=0 stays, then clears.
    drv(17'd2, 17'd3, 1'b0, 1'b0, 1'b0, 1'b1);
    wait_ov(0, lat);
    #1;
    ce = 1'b0;
    idle(1);
    chk("stretch_hold", o_ov(0), 1);
    chk("stretch_acc", o_acc(0), 6);
    ce = 1'b1;
    idle(1);
    chk("stretch_clear", o_ov(0), 0);
    idle(2);

    // Reset mid-frame; next frame starts with acc_en=1 and must load.
    drv(17'd4, 17'd4, 1'b0, 1'b0, 1'b0, 1'b0);
    drv(17'd4, 17'd4, 1'b0, 1'b0, 1'b1, 1'b0);
    idle(1);
    rst = 1'b1;
    #1;
    chk_zero("midrst");
    #2;
    rst = 1'b0;
    idle(1);
    drv(17'd6, 17'd7, 1'b0, 1'b0, 1'b1, 1'b0);
    drv(17'd2, 17'd2, 1'b0, 1'b0, 1'b1, 1'b1);
    wait_ov(1, lat);
    chk("postrst_acc1", o_acc(1), 46);
    wait_ov(0, lat);
    chk("postrst_lat0", lat, 5);
    chk("postrst_acc0", o_acc(0), 46);
    idle(3);

    // Random stream against the reference model.
    rst = 1'b1;
    #2;
    rst = 1'b0;
    idle(1);
    m_started = 1'b0;
    m_sum[0] = 0; m_sum[1] = 0;
    m_ovf[0] = 1'b0; m_ovf[1] = 1'b0;
    rnd_on = 1'b1;
    for (int it = 0; it < 3000; it++) begin
      ce  = ($urandom % 10) != 0;
      vld = ($urandom % 4) != 0;
      a   = 17'($urandom);
      b   = 17'($urandom);
      as_ = 1'($urandom);
      bs_ = 1'($urandom);
      en  = ($urandom % 5) != 0;
      lst = ($urandom % 5) == 0;
      if (ce && vld) model_take(a, b, as_, bs_, en, lst);
      @(posedge clk);
      #1;
    end
    vld = 1'b0;
    ce = 1'b1;
    idle(20);
    rnd_on = 1'b0;
    chk("rnd_left0", q0.size(), 0);
    chk("rnd_left1", q1.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
